mem_stage: RTL and testbench

- Memory stage of the multi-cycle core.
- Consumes load/store requests produced by the ALU stage (valid, load/store flags, ALU-computed address, rs2 store data, access size, destination register) and drives a data-memory request/response port.
- Returns sign-extended load data and completion to writeback.
- Asserts the stall back to the ALU stage while a memory access is outstanding.

---
 rtl/mem_stage_if.sv | 71 +++++++
 rtl/mem_stage.sv | 167 ++++++++++++++++
 tb/tb_mem_stage.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Shared sizing package and the ALU-stage / data-memory / writeback bundle of mem_stage.
// misaligned exists only when MEM_MISALIGN_CHECK_EN is defined.
package params_pkg;
  parameter int DATA_WIDTH     = 32;
  parameter int ADDR_WIDTH     = 32;
  parameter int REGISTER_WIDTH = 5;

  typedef enum logic {
    BYTE = 1'b0,
    WORD = 1'b1
  } access_size_t;
endpackage

interface mem_stage_if #(
  parameter int DATA_WIDTH     = params_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH     = params_pkg::ADDR_WIDTH,
  parameter int REGISTER_WIDTH = params_pkg::REGISTER_WIDTH
);
  import params_pkg::*;

  // ALU stage side
  logic                      valid;
  logic                      is_load;
  logic                      is_store;
  logic                      reg_wr_en;
  access_size_t              access_size;
  logic [ADDR_WIDTH-1:0]     addr;
  logic [DATA_WIDTH-1:0]     wr_data;
  logic [REGISTER_WIDTH-1:0] rd;
  logic                      stall;

  // data memory side
  logic                      dmem_req;
  logic                      dmem_we;
  logic [ADDR_WIDTH-1:0]     dmem_addr;
  logic [DATA_WIDTH-1:0]     dmem_wdata;
  logic [DATA_WIDTH/8-1:0]   dmem_be;
  logic                      dmem_ready;
  logic                      dmem_rvalid;
  logic [DATA_WIDTH-1:0]     dmem_rdata;

  // writeback side
  logic                      wb_valid;
  logic                      wb_reg_wr_en;
  logic [REGISTER_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0]     wb_data;
  logic                      instr_finishes;
`ifdef MEM_MISALIGN_CHECK_EN
  logic                      misaligned;
`endif

  modport master (
    input  valid, is_load, is_store, reg_wr_en, access_size, addr, wr_data, rd,
    input  dmem_ready, dmem_rvalid, dmem_rdata,
`ifdef MEM_MISALIGN_CHECK_EN
    output misaligned,
`endif
    output stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output wb_valid, wb_reg_wr_en, wb_rd, wb_data, instr_finishes
  );

  modport slave (
    output valid, is_load, is_store, reg_wr_en, access_size, addr, wr_data, rd,
    output dmem_ready, dmem_rvalid, dmem_rdata,
`ifdef MEM_MISALIGN_CHECK_EN
    input  misaligned,
`endif
    input  stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  wb_valid, wb_reg_wr_en, wb_rd, wb_data, instr_finishes
  );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: issues one load/store at a time to data memory and returns the result to writeback.
// Optional MEM_MISALIGN_CHECK_EN rejects misaligned WORD ops without touching memory.
module mem_stage #(
  parameter int DATA_WIDTH     = params_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH     = params_pkg::ADDR_WIDTH,
  parameter int REGISTER_WIDTH = params_pkg::REGISTER_WIDTH
) (
  input  logic        clk_i,
  input  logic        rst_i,
  mem_stage_if.master bus
);
  import params_pkg::*;

  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(NUM_LANES);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  state_t                    state_reg;
  logic                      req_reg;
  logic                      we_reg;
  logic [ADDR_WIDTH-1:0]     addr_reg;
  logic [DATA_WIDTH-1:0]     wdata_reg;
  logic [NUM_LANES-1:0]      be_reg;
  logic                      wb_valid_reg;
  logic                      wb_wr_en_reg;
  logic [REGISTER_WIDTH-1:0] wb_rd_reg;
  logic [DATA_WIDTH-1:0]     wb_data_reg;
  logic                      load_reg;
  logic                      word_reg;
  logic [LANE_BITS-1:0]      lane_reg;
  logic                      wr_en_hold_reg;
  logic [REGISTER_WIDTH-1:0] rd_hold_reg;

  logic                      accept;
  logic                      word_next;
  logic [LANE_BITS-1:0]      lane_next;
  logic [DATA_WIDTH-1:0]     byte_rep;
  logic [NUM_LANES-1:0]      byte_be;
  logic [DATA_WIDTH-1:0]     wdata_next;
  logic [NUM_LANES-1:0]      be_next;
  logic [7:0]                rdata_bytes [NUM_LANES];
  logic [7:0]                sel_byte;
  logic [DATA_WIDTH-1:0]     load_result;
  logic                      load_done;

  assign accept    = bus.valid && (bus.is_load || bus.is_store);
  assign word_next = (bus.access_size == WORD);
  assign lane_next = bus.addr[LANE_BITS-1:0];

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign byte_rep[gi*8 +: 8] = bus.wr_data[7:0];
      assign byte_be[gi]         = (lane_next == LANE_BITS'(gi));
      assign rdata_bytes[gi]     = bus.dmem_rdata[gi*8 +: 8];
    end
  endgenerate

  assign wdata_next  = word_next ? bus.wr_data : byte_rep;
  assign be_next     = word_next ? '1 : byte_be;
  assign sel_byte    = rdata_bytes[lane_reg];
  assign load_result = word_reg ? bus.dmem_rdata : {{(DATA_WIDTH-8){sel_byte[7]}}, sel_byte};

  // Read data arriving in the handshake cycle itself counts as the completion.
  assign load_done = ((state_reg == REQ) && bus.dmem_ready && load_reg && bus.dmem_rvalid) ||
                     ((state_reg == WAIT) && bus.dmem_rvalid);

`ifdef MEM_MISALIGN_CHECK_EN
  logic misaligned_reg;
  logic misaligned_next;
  assign misaligned_next = word_next && (lane_next != '0);
  assign bus.misaligned  = misaligned_reg;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      req_reg        <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      be_reg         <= '0;
      wb_valid_reg   <= 1'b0;
      wb_wr_en_reg   <= 1'b0;
      wb_rd_reg      <= '0;
      wb_data_reg    <= '0;
      load_reg       <= 1'b0;
      word_reg       <= 1'b0;
      lane_reg       <= '0;
      wr_en_hold_reg <= 1'b0;
      rd_hold_reg    <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
      misaligned_reg <= 1'b0;
`endif
    end else begin
      wb_valid_reg <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      misaligned_reg <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (accept) begin
            load_reg       <= !bus.is_store;
            word_reg       <= word_next;
            lane_reg       <= lane_next;
            wr_en_hold_reg <= bus.reg_wr_en;
            rd_hold_reg    <= bus.rd;
`ifdef MEM_MISALIGN_CHECK_EN
            if (misaligned_next) begin
              wb_valid_reg   <= 1'b1;
              wb_wr_en_reg   <= 1'b0;
              misaligned_reg <= 1'b1;
            end else
`endif
            begin
              req_reg   <= 1'b1;
              we_reg    <= bus.is_store;
              addr_reg  <= bus.addr;
              wdata_reg <= wdata_next;
              be_reg    <= be_next;
              state_reg <= REQ;
            end
          end
        end
        REQ: begin
          if (bus.dmem_ready) begin
            req_reg <= 1'b0;
            if (!load_reg) begin
              state_reg    <= IDLE;
              wb_valid_reg <= 1'b1;
              wb_wr_en_reg <= 1'b0;
              wb_rd_reg    <= rd_hold_reg;
            end else begin
              state_reg <= WAIT;
            end
          end
        end
        WAIT: ;
        default: state_reg <= IDLE;
      endcase

      if (load_done) begin
        state_reg    <= IDLE;
        wb_valid_reg <= 1'b1;
        wb_wr_en_reg <= wr_en_hold_reg;
        wb_rd_reg    <= rd_hold_reg;
        wb_data_reg  <= load_result;
      end
    end
  end

  assign bus.stall          = (state_reg != IDLE);
  assign bus.dmem_req       = req_reg;
  assign bus.dmem_we        = we_reg;
  assign bus.dmem_addr      = addr_reg;
  assign bus.dmem_wdata     = wdata_reg;
  assign bus.dmem_be        = be_reg;
  assign bus.wb_valid       = wb_valid_reg;
  assign bus.wb_reg_wr_en   = wb_wr_en_reg;
  assign bus.wb_rd          = wb_rd_reg;
  assign bus.wb_data        = wb_data_reg;
  assign bus.instr_finishes = wb_valid_reg;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios with literal expectations, then randomized ops and
// memory timing, all checked every cycle against a transaction-level model of the stage.
module tb_mem_stage;
  import params_pkg::*;

  logic clk = 1'b0;
  logic srst = 1'b1;
  always #5 clk = ~clk;

  mem_stage_if bus ();
  mem_stage dut (.clk_i(clk), .rst_i(srst), .bus(bus));

  int total = 0;
  int bad = 0;
  int n_hs = 0, n_wb = 0, n_stall = 0;
  logic checking = 1'b0;
  logic rand_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] f_wdata(input logic word, input logic [31:0] d);
    return word ? d : (d & 32'hFF) * 32'h01010101;
  endfunction

  function automatic logic [3:0] f_be(input logic word, input logic [31:0] a);
    return word ? 4'hF : 4'(1 << (a % 4));
  endfunction

  function automatic logic [31:0] f_load(input logic word, input logic [1:0] lane, input logic [31:0] r);
    logic [31:0] b;
    if (word) return r;
    b = (r >> (8 * lane)) & 32'hFF;
    return (b >= 128) ? (b | 32'hFFFFFF00) : b;
  endfunction

  // ---------------- transaction-level model ----------------
  logic        m_busy, m_hs, m_load, m_word, m_wr_en;
  logic [1:0]  m_lane;
  logic [4:0]  m_rd;
  logic        exp_req, exp_we, exp_wb_valid, exp_wb_wr_en, exp_mis;
  logic [31:0] exp_addr, exp_wdata, exp_wb_data;
  logic [3:0]  exp_be;
  logic [4:0]  exp_wb_rd;
  int          acc_cnt = 0;

  always @(posedge clk) begin
    exp_wb_valid <= 1'b0;
    exp_mis      <= 1'b0;
    if (srst) begin
      m_busy <= 1'b0; m_hs <= 1'b0; m_load <= 1'b0;
      exp_req <= 1'b0; exp_we <= 1'b0; exp_addr <= '0; exp_wdata <= '0; exp_be <= '0;
      exp_wb_wr_en <= 1'b0; exp_wb_rd <= '0; exp_wb_data <= '0;
    end else if (!m_busy) begin
      if (bus.valid && (bus.is_load || bus.is_store)) begin
        acc_cnt <= acc_cnt + 1;
`ifdef MEM_MISALIGN_CHECK_EN
        if (bus.access_size == WORD && bus.addr % 4 != 0) begin
          exp_wb_valid <= 1'b1;
          exp_wb_wr_en <= 1'b0;
          exp_mis      <= 1'b1;
        end else
`endif
        begin
          m_busy    <= 1'b1;
          m_hs      <= 1'b0;
          m_load    <= !bus.is_store;
          m_word    <= (bus.access_size == WORD);
          m_lane    <= bus.addr[1:0];
          m_wr_en   <= bus.reg_wr_en;
          m_rd      <= bus.rd;
          exp_req   <= 1'b1;
          exp_we    <= bus.is_store;
          exp_addr  <= bus.addr;
          exp_wdata <= f_wdata(bus.access_size == WORD, bus.wr_data);
          exp_be    <= f_be(bus.access_size == WORD, bus.addr);
        end
      end
    end else if (!m_hs && bus.dmem_ready && !m_load) begin
      exp_req <= 1'b0; m_busy <= 1'b0;
      exp_wb_valid <= 1'b1; exp_wb_wr_en <= 1'b0; exp_wb_rd <= m_rd;
    end else if ((!m_hs && bus.dmem_ready && bus.dmem_rvalid) || (m_hs && bus.dmem_rvalid)) begin
      exp_req <= 1'b0; m_busy <= 1'b0;
      exp_wb_valid <= 1'b1; exp_wb_wr_en <= m_wr_en; exp_wb_rd <= m_rd;
      exp_wb_data  <= f_load(m_word, m_lane, bus.dmem_rdata);
    end else if (!m_hs && bus.dmem_ready) begin
      exp_req <= 1'b0; m_hs <= 1'b1;
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (checking) begin
      chk("stall", 32'(bus.stall), 32'(m_busy));
      chk("dmem_req", 32'(bus.dmem_req), 32'(exp_req));
      if (exp_req) begin
        chk("dmem_we", 32'(bus.dmem_we), 32'(exp_we));
        chk("dmem_addr", bus.dmem_addr, exp_addr);
        chk("dmem_wdata", bus.dmem_wdata, exp_wdata);
        chk("dmem_be", 32'(bus.dmem_be), 32'(exp_be));
      end
      chk("wb_valid", 32'(bus.wb_valid), 32'(exp_wb_valid));
      chk("instr_finishes", 32'(bus.instr_finishes), 32'(exp_wb_valid));
      if (exp_wb_valid) chk("wb_reg_wr_en", 32'(bus.wb_reg_wr_en), 32'(exp_wb_wr_en));
      if (exp_wb_valid && exp_wb_wr_en) begin
        chk("wb_rd", 32'(bus.wb_rd), 32'(exp_wb_rd));
        chk("wb_data", bus.wb_data, exp_wb_data);
      end
`ifdef MEM_MISALIGN_CHECK_EN
      chk("misaligned", 32'(bus.misaligned), 32'(exp_mis));
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    if (bus.dmem_req && bus.dmem_ready) n_hs++;
    @(posedge clk);
    #1;
    if (bus.wb_valid) n_wb++;
    if (bus.stall) n_stall++;
  endtask

  task automatic set_op(input logic ld, input logic word, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd, input logic wr_en);
    bus.valid       = 1'b1;
    bus.is_load     = ld;
    bus.is_store    = !ld;
    bus.reg_wr_en   = wr_en;
    bus.access_size = word ? WORD : BYTE;
    bus.addr        = a;
    bus.wr_data     = wd;
    bus.rd          = rd;
  endtask

  task automatic dir_load(input logic word, input logic [31:0] a, input logic [4:0] rd,
                          input int rdy_dly, input int rv_dly, input logic [31:0] rdata);
    set_op(1'b1, word, a, 32'h0, rd, 1'b1);
    tick();
    bus.valid = 1'b0;
    repeat (rdy_dly) tick();
    bus.dmem_ready = 1'b1;
    if (rv_dly == 0) begin
      bus.dmem_rvalid = 1'b1;
      bus.dmem_rdata  = rdata;
    end
    tick();
    bus.dmem_ready  = 1'b0;
    bus.dmem_rvalid = 1'b0;
    if (rv_dly > 0) begin
      repeat (rv_dly - 1) tick();
      bus.dmem_rvalid = 1'b1;
      bus.dmem_rdata  = rdata;
      tick();
      bus.dmem_rvalid = 1'b0;
    end
  endtask

  task automatic drive_random();
    logic        ld, word, wr_en;
    logic [31:0] a, wd;
    logic [4:0]  rd;
    int          start, to, gap;
    for (int i = 0; i < 300; i++) begin
      ld    = 1'($urandom % 2);
      word  = 1'($urandom % 2);
      a     = $urandom;
      if (word && ($urandom % 8 != 0)) a[1:0] = 2'b00;
      wd    = $urandom;
      rd    = 5'($urandom % 32);
      wr_en = ld ? ($urandom % 4 != 0) : 1'b0;
      set_op(ld, word, a, wd, rd, wr_en);
      start = acc_cnt;
      to = 0;
      while (acc_cnt == start && to < 200) begin
        tick();
        to++;
      end
      if (acc_cnt == start) begin
        chk("accept_timeout", 32'(acc_cnt), 32'(start + 1));
        break;
      end
      gap = $urandom % 3;
      for (int g = 0; g < gap; g++) begin
        bus.valid    = 1'($urandom % 2);
        bus.is_load  = 1'b0;
        bus.is_store = 1'b0;
        bus.addr     = $urandom;
        tick();
      end
    end
    bus.valid = 1'b0;
    for (int w = 0; w < 200 && m_busy; w++) tick();
    if (m_busy) chk("drain_timeout", 32'(m_busy), 32'd0);
  endtask

  task automatic respond_random();
    while (!rand_done) begin
      bus.dmem_ready  = ($urandom % 3 == 0);
      bus.dmem_rvalid = 1'b0;
      if (m_busy && m_load && (m_hs || bus.dmem_ready)) bus.dmem_rvalid = 1'($urandom % 2);
      else if (!m_busy) bus.dmem_rvalid = ($urandom % 8 == 0);
      bus.dmem_rdata = $urandom;
      tick();
    end
    bus.dmem_ready  = 1'b0;
    bus.dmem_rvalid = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bus.valid = 1'b0; bus.is_load = 1'b0; bus.is_store = 1'b0; bus.reg_wr_en = 1'b0;
    bus.access_size = BYTE; bus.addr = '0; bus.wr_data = '0; bus.rd = '0;
    bus.dmem_ready = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    srst = 1'b0;
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_req", 32'(bus.dmem_req), 32'd0);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    checking = 1'b1;

    // LW with delayed ready and delayed read data
    n_stall = 0; n_wb = 0;
    dir_load(1'b1, 32'h100, 5'd5, 2, 3, 32'hDEADBEEF);
    chk("lw_wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("lw_wb_data", bus.wb_data, 32'hDEADBEEF);
    chk("lw_wb_rd", 32'(bus.wb_rd), 32'd5);
    chk("lw_wb_wr_en", 32'(bus.wb_reg_wr_en), 32'd1);
    chk("lw_stall_5plus", 32'(n_stall >= 5), 32'd1);
    tick();
    chk("lw_one_pulse", 32'(n_wb), 32'd1);

    // LB sign extension, top lane negative, lane 1 positive (same-cycle rvalid on the first)
    dir_load(1'b0, 32'h203, 5'd6, 0, 0, 32'h80123456);
    chk("lb_203_data", bus.wb_data, 32'hFFFFFF80);
    tick();
    dir_load(1'b0, 32'h201, 5'd7, 1, 1, 32'h80123456);
    chk("lb_201_data", bus.wb_data, 32'h00000034);
    tick();

    // SB to lane 2, ready immediately
    set_op(1'b0, 1'b0, 32'h302, 32'h000000A5, 5'd0, 1'b0);
    tick();
    bus.valid = 1'b0;
    chk("sb_req", 32'(bus.dmem_req), 32'd1);
    chk("sb_we", 32'(bus.dmem_we), 32'd1);
    chk("sb_be", 32'(bus.dmem_be), 32'h4);
    chk("sb_wdata", bus.dmem_wdata, 32'hA5A5A5A5);
    bus.dmem_ready = 1'b1;
    tick();
    bus.dmem_ready = 1'b0;
    chk("sb_wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("sb_wb_wr_en", 32'(bus.wb_reg_wr_en), 32'd0);
    chk("sb_no_wait", 32'(bus.stall), 32'd0);
    tick();

    // Back-to-back SW, second held while stalled
    n_hs = 0; n_wb = 0;
    set_op(1'b0, 1'b1, 32'h400, 32'h11111111, 5'd0, 1'b0);
    tick();
    set_op(1'b0, 1'b1, 32'h404, 32'h22222222, 5'd0, 1'b0);
    chk("b2b_stalled", 32'(bus.stall), 32'd1);
    tick();
    chk("b2b_first_addr_held", bus.dmem_addr, 32'h400);
    bus.dmem_ready = 1'b1;
    tick();
    bus.dmem_ready = 1'b0;
    chk("b2b_first_done", 32'(bus.wb_valid), 32'd1);
    tick();
    bus.valid = 1'b0;
    chk("b2b_second_req", 32'(bus.dmem_req), 32'd1);
    chk("b2b_second_addr", bus.dmem_addr, 32'h404);
    chk("b2b_second_wdata", bus.dmem_wdata, 32'h22222222);
    bus.dmem_ready = 1'b1;
    tick();
    bus.dmem_ready = 1'b0;
    tick();
    chk("b2b_requests", 32'(n_hs), 32'd2);
    chk("b2b_pulses", 32'(n_wb), 32'd2);

    // Reset while waiting for read data, then a stray rvalid
    set_op(1'b1, 1'b1, 32'h500, 32'h0, 5'd9, 1'b1);
    tick();
    bus.valid = 1'b0;
    bus.dmem_ready = 1'b1;
    tick();
    bus.dmem_ready = 1'b0;
    tick();
    chk("rst_wait_stall", 32'(bus.stall), 32'd1);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    n_wb = 0;
    chk("rstw_stall", 32'(bus.stall), 32'd0);
    chk("rstw_req", 32'(bus.dmem_req), 32'd0);
    chk("rstw_addr", bus.dmem_addr, 32'd0);
    chk("rstw_be", 32'(bus.dmem_be), 32'd0);
    chk("rstw_wb_rd", 32'(bus.wb_rd), 32'd0);
    chk("rstw_wb_data", bus.wb_data, 32'd0);
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'h12345678;
    tick();
    bus.dmem_rvalid = 1'b0;
    tick();
    chk("stray_rvalid_no_pulse", 32'(n_wb), 32'd0);
    chk("stray_rvalid_stall", 32'(bus.stall), 32'd0);

`ifdef MEM_MISALIGN_CHECK_EN
    set_op(1'b1, 1'b1, 32'h102, 32'h0, 5'd4, 1'b1);
    tick();
    bus.valid = 1'b0;
    chk("mis_wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("mis_flag", 32'(bus.misaligned), 32'd1);
    chk("mis_wr_en", 32'(bus.wb_reg_wr_en), 32'd0);
    chk("mis_no_req", 32'(bus.dmem_req), 32'd0);
    tick();
    chk("mis_flag_drop", 32'(bus.misaligned), 32'd0);
    chk("mis_valid_drop", 32'(bus.wb_valid), 32'd0);
`endif

    // Randomized ops against randomized memory timing
    fork
      begin
        drive_random();
        rand_done = 1'b1;
      end
      respond_random();
    join
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
